mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like memory bus between ibus (fetch) and dbus (data), one transaction in flight.
// Define MEM_ARB_STAT_EN to add the stat_icnt/stat_dcnt/stat_iwait counters.
module mem_bus_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
`ifdef MEM_ARB_STAT_EN
  ,
  output logic [31:0] stat_icnt,
  output logic [31:0] stat_dcnt,
  output logic [31:0] stat_iwait
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DSTREAK);

  logic [1:0] stateQ, stateD;
  logic [1:0] ownerQ, ownerD;
  logic [3:0] dstreakQ, dstreakD;
  logic       iOwn, dOwn, addrOk, respOk;

  assign iOwn = (ownerQ == OWN_I);
  assign dOwn = (ownerQ == OWN_D);

  assign addrOk = (stateQ == ADDR) && m_addr_ok;
  // A response completes either coincident with the address handshake or later in DATA.
  assign respOk = (addrOk && m_data_ok) || ((stateQ == DATA) && m_data_ok);

  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wstrb = 4'd0;
    m_wdata = 32'd0;
    if (stateQ == ADDR) begin
      m_req = 1'b1;
      if (dOwn) begin
        m_wr    = d_wr;
        m_size  = d_size;
        m_addr  = d_addr;
        m_wstrb = d_wstrb;
        m_wdata = d_wdata;
      end else if (iOwn) begin
        m_size = 2'd2;
        m_addr = i_addr;
      end
    end
  end

  assign i_addr_ok = addrOk && iOwn;
  assign d_addr_ok = addrOk && dOwn;
  assign i_data_ok = respOk && iOwn;
  assign d_data_ok = respOk && dOwn;
  assign i_rdata   = i_data_ok ? m_rdata : 32'd0;
  assign d_rdata   = d_data_ok ? m_rdata : 32'd0;

  always_comb begin
    stateD   = stateQ;
    ownerD   = ownerQ;
    dstreakD = dstreakQ;
    case (stateQ)
      IDLE: begin
        // Data wins unless fetch has already waited out a full streak of data grants.
        if (d_req && !(i_req && (dstreakQ == MAX_STREAK))) begin
          ownerD = OWN_D;
          stateD = ADDR;
          if (!i_req) begin
            dstreakD = 4'd0;
          end else if (dstreakQ >= MAX_STREAK) begin
            dstreakD = MAX_STREAK;
          end else begin
            dstreakD = dstreakQ + 4'd1;
          end
        end else if (i_req) begin
          ownerD   = OWN_I;
          stateD   = ADDR;
          dstreakD = 4'd0;
        end
      end
      ADDR: begin
        if (m_addr_ok) begin
          if (m_data_ok) begin
            stateD = IDLE;
            ownerD = OWN_NONE;
          end else begin
            stateD = DATA;
          end
        end
      end
      DATA: begin
        if (m_data_ok) begin
          stateD = IDLE;
          ownerD = OWN_NONE;
        end
      end
      default: begin
        stateD = IDLE;
        ownerD = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ   <= IDLE;
      ownerQ   <= OWN_NONE;
      dstreakQ <= 4'd0;
    end else begin
      stateQ   <= stateD;
      ownerQ   <= ownerD;
      dstreakQ <= dstreakD;
    end
  end

`ifdef MEM_ARB_STAT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_icnt  <= 32'd0;
      stat_dcnt  <= 32'd0;
      stat_iwait <= 32'd0;
    end else begin
      if (i_data_ok) stat_icnt <= stat_icnt + 32'd1;
      if (d_data_ok) stat_dcnt <= stat_dcnt + 32'd1;
      if (i_req && !iOwn) stat_iwait <= stat_iwait + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // The granted requester must keep req high until its address is accepted.
  reqHeldInAddr: assert property (@(posedge clk) disable iff (!resetn)
    (stateQ == ADDR) |-> (iOwn ? i_req : d_req));
`endif

endmodule
